// File: rtl/spi_slave_rx_queue.sv
// SPI mode-0 slave receiver: buffers each cs-low frame in a byte FIFO, then replays
// it in the c domain as a header byte followed by the payload, with rxe on the last byte.
module spi_slave_rx_queue #(
    parameter logic [7:0] HEADER = 8'h99,
    parameter int         DEPTH  = 256,
    parameter int         AW     = 8
) (
    input  logic       c,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic [7:0] rxd,
    output logic       rxdv,
    output logic       rxe
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Valid/ready: there is no back-pressure; every cycle with rxdv=1 carries one byte
    // that the consumer must accept, and rxe qualifies the final payload byte.

    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_prev, sclk_prev;
    logic       cs_fall, cs_rise, sclk_rise;

    always_ff @(posedge c) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;
    assign sclk_rise = sclk_sync[1] & ~sclk_prev & ~cs_sync[1];

    logic [6:0] shreg;
    logic [2:0] bitcnt;
    logic       byte_done;
    logic [7:0] byte_data;

    always_ff @(posedge c) begin
        if (rst) begin
            shreg     <= '0;
            bitcnt    <= '0;
            byte_done <= 1'b0;
            byte_data <= '0;
        end else begin
            byte_done <= 1'b0;
            if (cs_fall || cs_rise) begin
                bitcnt <= '0;
            end else if (sclk_rise) begin
                shreg  <= {shreg[5:0], mosi_sync[1]};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_data <= {shreg, mosi_sync[1]};
                end
            end
        end
    end

    logic [1:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push_ok, pop;

    assign push_ok = byte_done && (count != CNT_FULL);
    assign pop     = (state == S_DRAIN) && (count != CNT_ZERO);

    always_ff @(posedge c) begin
        if (push_ok) mem[wptr] <= byte_data;
    end

    always_ff @(posedge c) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Only accepted bytes are counted, so the drain length always matches what the FIFO holds.
    logic [AW:0] frame_cnt, frame_cnt_next, fe_cnt;
    logic        frame_end;

    always_comb begin
        frame_cnt_next = frame_cnt;
        if (push_ok && frame_cnt != CNT_FULL) frame_cnt_next = frame_cnt + CNT_ONE;
    end

    always_ff @(posedge c) begin
        if (rst) begin
            frame_cnt <= '0;
            fe_cnt    <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (cs_fall) begin
                frame_cnt <= '0;
            end else if (cs_rise) begin
                frame_cnt <= '0;
                if (frame_cnt_next != CNT_ZERO) begin
                    frame_end <= 1'b1;
                    fe_cnt    <= frame_cnt_next;
                end
            end else begin
                frame_cnt <= frame_cnt_next;
            end
        end
    end

    // A frame that ends while a replay is still running waits here until IDLE.
    logic        pend;
    logic [AW:0] pend_cnt, drain_cnt;

    always_ff @(posedge c) begin
        if (rst) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            pend_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (frame_end && (state != S_IDLE || pend)) begin
                pend     <= 1'b1;
                pend_cnt <= fe_cnt;
            end else if (state == S_IDLE && pend) begin
                pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend) begin
                        state     <= S_HEADER;
                        drain_cnt <= pend_cnt;
                    end else if (frame_end) begin
                        state     <= S_HEADER;
                        drain_cnt <= fe_cnt;
                    end
                end
                S_HEADER: state <= S_DRAIN;
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_ONE;
                    if (drain_cnt <= CNT_ONE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rxdv = 1'b0;
        rxe  = 1'b0;
        rxd  = 8'h00;
        if (!rst) begin
            case (state)
                S_HEADER: begin
                    rxdv = 1'b1;
                    rxd  = HEADER;
                end
                S_DRAIN: begin
                    rxdv = 1'b1;
                    rxd  = mem[rptr];
                    rxe  = (drain_cnt == CNT_ONE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_queue.sv
// Bench for spi_slave_rx_queue: drives SPI mode-0 frames and checks the replayed
// byte stream against an expected queue of {rxe, rxd} entries.
module tb_spi_slave_rx_queue;
    localparam logic [7:0] HDR = 8'h99;

    logic       c = 1'b0;
    logic       rst, cs, sclk, mosi;
    logic [7:0] rxd;
    logic       rxdv, rxe;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic       open_frame = 1'b0;

    spi_slave_rx_queue dut (
        .c    (c),
        .rst  (rst),
        .cs   (cs),
        .sclk (sclk),
        .mosi (mosi),
        .rxd  (rxd),
        .rxdv (rxdv),
        .rxe  (rxe)
    );

    always #5 c = ~c;

    // Scoreboard: every rxdv cycle pops one expected entry; an open frame must not gap.
    always @(negedge c) begin
        if (rst === 1'b1) begin
            open_frame = 1'b0;
        end else begin
            if (open_frame) begin
                checks++;
                if (rxdv !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_gap rxdv=%b expected rxdv=1", rxdv);
                end
            end
            if (rxdv === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte rxd=%h rxe=%b expected no output", rxd, rxe);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({rxe, rxd} !== exp_item) begin
                        failures++;
                        $display("FAIL stream_byte rxd=%h rxe=%b expected rxd=%h rxe=%b",
                                 rxd, rxe, exp_item[7:0], exp_item[8]);
                    end
                end
                open_frame = (rxe !== 1'b1);
            end else begin
                open_frame = 1'b0;
            end
        end
    end

    task automatic spi_cs_low(input bit expect_hdr);
        if (expect_hdr) exp_q.push_back({1'b0, HDR});
        cs = 1'b0;
        #100;
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit expect_out, input bit last);
        if (expect_out) exp_q.push_back({last, b});
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
    endtask

    task automatic spi_cs_high;
        #100 cs = 1'b1;
    endtask

    task automatic wait_drained(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge c);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout remaining=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input int ncyc, input string name);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge c);
            if (rxdv !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s rxdv_cycles=%0d expected=0", name, seen);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge c);
        checks++;
        if (rxdv !== 1'b0) begin failures++; $display("FAIL reset_rxdv got=%b expected=0", rxdv); end
        checks++;
        if (rxe !== 1'b0) begin failures++; $display("FAIL reset_rxe got=%b expected=0", rxe); end
        checks++;
        if (rxd !== 8'h00) begin failures++; $display("FAIL reset_rxd got=%h expected=00", rxd); end
        rst = 1'b0;
        repeat (5) @(negedge c);
    endtask

    task automatic test_single_frame;
        spi_cs_low(1'b1);
        spi_byte(8'hA5, 1'b1, 1'b0);
        spi_byte(8'h07, 1'b1, 1'b0);
        spi_byte(8'h51, 1'b1, 1'b1);
        spi_cs_high();
        wait_drained(200, "single_frame");
        check_quiet(20, "single_frame_quiet");
    endtask

    task automatic test_second_frame;
        spi_cs_low(1'b1);
        spi_byte(8'hA5, 1'b1, 1'b1);
        spi_cs_high();
        wait_drained(200, "second_frame");
        check_quiet(30, "second_frame_residue");
    endtask

    task automatic test_partial_frame;
        spi_cs_low(1'b0);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        spi_cs_high();
        check_quiet(60, "partial_frame");
    endtask

    task automatic test_reset_mid_drain;
        bit found = 1'b0;
        spi_cs_low(1'b1);
        spi_byte(8'h11, 1'b1, 1'b0);
        spi_byte(8'h22, 1'b1, 1'b0);
        spi_byte(8'h33, 1'b1, 1'b0);
        spi_byte(8'h44, 1'b1, 1'b0);
        spi_byte(8'h55, 1'b1, 1'b1);
        spi_cs_high();
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge c);
            if (rxdv === 1'b1 && rxd === 8'h22) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_drain_second_byte found=0 expected=1");
        end
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge c);
        checks++;
        if (rxdv !== 1'b0) begin failures++; $display("FAIL mid_drain_rxdv got=%b expected=0", rxdv); end
        checks++;
        if (rxd !== 8'h00) begin failures++; $display("FAIL mid_drain_rxd got=%h expected=00", rxd); end
        checks++;
        if (rxe !== 1'b0) begin failures++; $display("FAIL mid_drain_rxe got=%b expected=0", rxe); end
        repeat (2) @(negedge c);
        rst = 1'b0;
        repeat (3) @(negedge c);
        spi_cs_low(1'b1);
        spi_byte(8'h3C, 1'b1, 1'b1);
        spi_cs_high();
        wait_drained(200, "after_reset_frame");
        check_quiet(30, "after_reset_quiet");
    endtask

    task automatic test_overflow;
        spi_cs_low(1'b1);
        for (int i = 0; i < 300; i++) begin
            spi_byte(8'(i), i < 256, i == 255);
        end
        spi_cs_high();
        wait_drained(400, "overflow");
        check_quiet(20, "overflow_quiet");
    endtask

    task automatic test_back_to_back;
        spi_cs_low(1'b1);
        for (int i = 0; i < 200; i++) begin
            spi_byte(8'(i * 3 + 1), 1'b1, i == 199);
        end
        spi_cs_high();
        #100;
        spi_cs_low(1'b1);
        spi_byte(8'hDE, 1'b1, 1'b0);
        spi_byte(8'hAD, 1'b1, 1'b0);
        spi_byte(8'hBE, 1'b1, 1'b1);
        spi_cs_high();
        wait_drained(400, "back_to_back");
        check_quiet(30, "back_to_back_quiet");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_second_frame();
        test_partial_frame();
        test_reset_mid_drain();
        test_overflow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
